// File: rtl/var_delay_pkg.sv
// Shared constants and helpers for the variable-latency delay line.
package var_delay_pkg;

  localparam int unsigned DefMaxCycles   = 8;
  localparam int unsigned DefWidth       = 32;
  localparam int unsigned DefLanes       = 1;
  localparam int unsigned DefDefaultDelay = 1;
  localparam int unsigned DefInitVal     = 0;

  // Bits needed to hold any latency value 0..max_cycles.
  function automatic int unsigned delay_width(input int unsigned max_cycles);
    return $clog2(max_cycles + 1);
  endfunction

endpackage

// File: rtl/var_delay_stage.sv
// One pipeline stage: a valid bit plus a data word. Only the valid bit is cleared by i_clr.
module var_delay_stage #(
  parameter int unsigned       WIDTH    = 32,
  parameter logic [WIDTH-1:0]  INIT_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  // Valid bit: clear wins over advance and is not gated by enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
    end else if (i_clr) begin
      r_valid <= 1'b0;
    end else if (i_en) begin
      r_valid <= i_valid;
    end
  end

  // Data word: advances with enable, untouched by clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= INIT_VAL;
    end else if (i_en) begin
      r_data <= i_data;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/var_delay.sv
// Delay line with run-time selectable latency 0..MAX_CYCLES, flush and in-flight beat count.
module var_delay
  import var_delay_pkg::*;
#(
  parameter int unsigned      MAX_CYCLES    = DefMaxCycles,
  parameter int unsigned      WIDTH         = DefWidth,
  parameter int unsigned      LANES         = DefLanes,
  parameter int unsigned      DEFAULT_DELAY = DefDefaultDelay,
  parameter logic [WIDTH-1:0] INIT_VAL      = WIDTH'(DefInitVal),
  localparam int unsigned     DW            = delay_width(MAX_CYCLES)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   flush,
  input  logic                   valid_in,
  input  logic [LANES*WIDTH-1:0] data_in,
  input  logic                   cfg_valid,
  input  logic [DW-1:0]          cfg_delay,
  output logic                   cfg_ready,
  output logic                   valid_out,
  output logic [LANES*WIDTH-1:0] data_out,
  output logic [DW-1:0]          cur_delay,
  output logic [DW-1:0]          count
);

  localparam int unsigned   DataW    = LANES * WIDTH;
  localparam logic [DW-1:0] MaxDelay = DW'(MAX_CYCLES);

  if (MAX_CYCLES < 1 || DEFAULT_DELAY > MAX_CYCLES) begin : g_bad_params
    $error("var_delay: need MAX_CYCLES >= 1 and DEFAULT_DELAY <= MAX_CYCLES");
  end

  logic [DW-1:0]         r_cur_delay;
  logic [DW-1:0]         r_count;
  logic                  w_bypass;
  logic                  w_cfg_load;
  logic                  w_clr;
  logic                  w_inc;
  logic                  w_dec;
  logic                  w_tap_valid;
  logic [DataW-1:0]      w_tap_data;
  logic [MAX_CYCLES-1:0] w_stage_valid;
  logic [DataW-1:0]      w_stage_data [MAX_CYCLES];

  assign w_bypass   = (r_cur_delay == '0);
  assign cfg_ready  = (r_count == '0) & ~valid_in & ~flush;
  assign w_cfg_load = cfg_valid & cfg_ready;
  // A config load drops every valid bit so no stale beat can reach a new tap.
  assign w_clr      = flush | w_cfg_load;

  for (genvar gi = 0; gi < MAX_CYCLES; gi++) begin : g_stage
    logic             w_d_valid;
    logic [DataW-1:0] w_d_data;

    if (gi == 0) begin : g_first
      assign w_d_valid = valid_in;
      assign w_d_data  = data_in;
    end else begin : g_next
      assign w_d_valid = w_stage_valid[gi-1];
      assign w_d_data  = w_stage_data[gi-1];
    end

    var_delay_stage #(
      .WIDTH   (DataW),
      .INIT_VAL({LANES{INIT_VAL}})
    ) u_stage (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_en   (en),
      .i_clr  (w_clr),
      .i_valid(w_d_valid),
      .i_data (w_d_data),
      .o_valid(w_stage_valid[gi]),
      .o_data (w_stage_data[gi])
    );
  end

  // Output tap: stage cur_delay-1; deeper stages never reach the output.
  always_comb begin
    w_tap_valid = 1'b0;
    w_tap_data  = w_stage_data[0];
    for (int i = 0; i < MAX_CYCLES; i++) begin
      if (r_cur_delay == DW'(i + 1)) begin
        w_tap_valid = w_stage_valid[i];
        w_tap_data  = w_stage_data[i];
      end
    end
  end

  assign valid_out = en & (w_bypass ? valid_in : w_tap_valid);
  assign data_out  = w_bypass ? data_in : w_tap_data;

  // Bypass beats never occupy a stage, so they are not counted.
  assign w_inc = en & valid_in & ~w_bypass;
  assign w_dec = valid_out & ~w_bypass;

  // In-flight counter, saturating at both ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (flush) begin
      r_count <= '0;
    end else if (w_inc && !w_dec && r_count != MaxDelay) begin
      r_count <= r_count + 1'b1;
    end else if (w_dec && !w_inc && r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  // Latency register, loaded only while the pipe is empty; clamps to MAX_CYCLES.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cur_delay <= DW'(DEFAULT_DELAY);
    end else if (w_cfg_load) begin
      r_cur_delay <= (cfg_delay > MaxDelay) ? MaxDelay : cfg_delay;
    end
  end

  assign cur_delay = r_cur_delay;
  assign count     = r_count;

endmodule

// File: tb/tb_var_delay.sv
// Scoreboard bench for var_delay: a beat-level model predicts outputs, a monitor checks them.
module tb_var_delay;

  localparam int unsigned MaxC  = 8;
  localparam int unsigned W     = 16;
  localparam int unsigned L     = 2;
  localparam int unsigned DefD  = 3;
  localparam int unsigned DW    = 4;
  localparam int unsigned DataW = W * L;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en;
  logic             flush;
  logic             valid_in;
  logic [DataW-1:0] data_in;
  logic             cfg_valid;
  logic [DW-1:0]    cfg_delay;
  logic             cfg_ready;
  logic             valid_out;
  logic [DataW-1:0] data_out;
  logic [DW-1:0]    cur_delay;
  logic [DW-1:0]    count;

  always #5 clk = ~clk;

  var_delay #(
    .MAX_CYCLES   (MaxC),
    .WIDTH        (W),
    .LANES        (L),
    .DEFAULT_DELAY(DefD),
    .INIT_VAL     (16'h0000)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .flush    (flush),
    .valid_in (valid_in),
    .data_in  (data_in),
    .cfg_valid(cfg_valid),
    .cfg_delay(cfg_delay),
    .cfg_ready(cfg_ready),
    .valid_out(valid_out),
    .data_out (data_out),
    .cur_delay(cur_delay),
    .count    (count)
  );

  // Model: each in-flight beat remembers how many enabled edges remain until it leaves.
  typedef struct {
    logic [DataW-1:0] data;
    int unsigned      rem;
  } beat_t;

  typedef struct {
    logic [DataW-1:0] data;
    int               cyc;
  } exp_t;

  beat_t       mq[$];
  exp_t        exp_q[$];
  exp_t        e;
  int unsigned m_delay = DefD;
  logic        m_ready = 1'b1;
  int          cyc     = 0;
  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_out   = 0;
  int          n0      = 0;
  int unsigned peak    = 0;
  bit          hold_rst = 1'b1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // One clock cycle of stimulus: drive at negedge, predict, then advance the model at posedge.
  task automatic drive(input logic e_i, input logic v, input logic f, input logic [DataW-1:0] d,
                       input logic cv, input logic [DW-1:0] cd);
    @(negedge clk);
    rst_n     = !hold_rst;
    en        = e_i;
    valid_in  = v;
    flush     = f;
    data_in   = d;
    cfg_valid = cv;
    cfg_delay = cd;
    cyc++;
    if (hold_rst) begin
      mq.delete();
      m_delay = DefD;
    end
    #1;
    m_ready = (mq.size() == 0) && !v && !f;
    if (m_delay == 0) begin
      if (v && e_i) exp_q.push_back('{d, cyc});
    end else if (e_i && mq.size() > 0 && mq[0].rem == 1) begin
      exp_q.push_back('{mq[0].data, cyc});
    end
    @(posedge clk);
    if (!hold_rst) begin
      if (f) begin
        mq.delete();
      end else if (e_i) begin
        foreach (mq[i]) mq[i].rem--;
        while (mq.size() > 0 && mq[0].rem == 0) void'(mq.pop_front());
        if (v && m_delay > 0) mq.push_back('{d, m_delay});
      end
      if (cv && m_ready) begin
        m_delay = (int'(cd) > MaxC) ? MaxC : int'(cd);
        mq.delete();
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic load(input logic [DW-1:0] cd);
    drive(1'b1, 1'b0, 1'b0, '0, 1'b1, cd);
  endtask

  // Monitor: samples mid-cycle, pops the scoreboard whenever the DUT presents a beat.
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (valid_out === 1'b1) begin
        n_out++;
        if (exp_q.size() == 0) begin
          check("unexpected valid_out", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("data_out", 64'(data_out), 64'(e.data));
          check("output cycle", 64'(cyc), 64'(e.cyc));
        end
      end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        check("missing valid_out", 64'd0, 64'd1);
        void'(exp_q.pop_front());
      end
      check("count", 64'(count), 64'(mq.size()));
      check("cur_delay", 64'(cur_delay), 64'(m_delay));
      check("cfg_ready", 64'(cfg_ready), 64'(m_ready));
      if (rst_n === 1'b0) check("reset data_out", 64'(data_out), 64'd0);
      if (int'(count) > peak) peak = int'(count);
    end
  end

  initial begin
    rst_n = 1'b0; en = 1'b0; flush = 1'b0; valid_in = 1'b0;
    data_in = '0; cfg_valid = 1'b0; cfg_delay = '0;

    // Reset, with traffic on the inputs that must not leak out.
    hold_rst = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 32'h1234_5678, 1'b0, '0);
    drive(1'b0, 1'b0, 1'b0, '0, 1'b1, 4'd6);
    hold_rst = 1'b0;

    // Two back-to-back beats at the reset latency.
    peak = 0;
    drive(1'b1, 1'b1, 1'b0, 32'h0001_0002, 1'b0, '0);
    drive(1'b1, 1'b1, 1'b0, 32'h0003_0004, 1'b0, '0);
    idle(5);
    check("peak count", 64'(peak), 64'd2);

    // Zero latency: combinational bypass.
    load(4'd0);
    n0 = n_out;
    drive(1'b1, 1'b1, 1'b0, 32'hAAAA_5555, 1'b0, '0);
    check("bypass beats", 64'(n_out - n0), 64'd1);

    // Latency 5 with a two-cycle stall mid-flight.
    load(4'd5);
    n0 = n_out;
    drive(1'b1, 1'b1, 1'b0, 32'hBEEF_0005, 1'b0, '0);
    idle(2);
    drive(1'b0, 1'b1, 1'b0, 32'hDEAD_0001, 1'b0, '0);
    drive(1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
    idle(6);
    check("stall beats", 64'(n_out - n0), 64'd1);

    // Latency 8, three beats, then flush with a concurrent beat.
    load(4'd8);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0, $urandom, 1'b0, '0);
    drive(1'b1, 1'b1, 1'b1, 32'h5A5A_A5A5, 1'b0, '0);
    n0 = n_out;
    idle(10);
    check("beats after flush", 64'(n_out - n0), 64'd0);

    // Config held off until the pipe drains; oversize request clamps.
    load(4'd4);
    drive(1'b1, 1'b1, 1'b0, 32'h0101_0202, 1'b0, '0);
    drive(1'b1, 1'b1, 1'b0, 32'h0303_0404, 1'b0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, 1'b1, 4'd12);
    #1;
    check("cur_delay held", 64'(cur_delay), 64'd4);
    repeat (6) drive(1'b1, 1'b0, 1'b0, '0, 1'b1, 4'd12);
    #1;
    check("cur_delay clamped", 64'(cur_delay), 64'd8);

    // Random traffic.
    repeat (400) begin
      drive(1'($urandom_range(3) != 0), 1'($urandom_range(1)), 1'($urandom_range(24) == 0),
            $urandom, 1'($urandom_range(9) == 0), 4'($urandom_range(15)));
    end
    idle(10);

    // Reset with four beats in flight.
    load(4'd8);
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 1'b0, $urandom, 1'b0, '0);
    n0 = n_out;
    hold_rst = 1'b1;
    idle(2);
    hold_rst = 1'b0;
    idle(10);
    check("beats after reset", 64'(n_out - n0), 64'd0);
    #1;
    check("cur_delay after reset", 64'(cur_delay), 64'(DefD));

    check("scoreboard empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/var_delay.md
VAR_DELAY -- requirements
Module: var_delay

Interface
REQ-001 Parameter MAX_CYCLES, default 8, meaning: deepest selectable latency (>=1).
REQ-002 Parameter WIDTH, default 32, meaning: bits per lane.
REQ-003 Parameter LANES, default 1, meaning: parallel data lanes sharing one valid.
REQ-004 Parameter DEFAULT_DELAY, default 1, meaning: latency after reset (0..MAX_CYCLES).
REQ-005 Parameter INIT_VAL, default 0, meaning: WIDTH-bit per-lane data reset value.
REQ-006 Port clk, input, 1, meaning: sole clock; all state on rising edge.
REQ-007 Port rst_n, input, 1, meaning: asynchronous, active-low reset.
REQ-008 Port en, input, 1, meaning: global advance; low freezes all stages.
REQ-009 Port flush, input, 1, meaning: discard all in-flight beats.
REQ-010 Port valid_in, input, 1, meaning: beat present on data_in.
REQ-011 Port data_in, input, LANES*WIDTH, meaning: lane-packed input, lane 0 in LSBs.
REQ-012 Port cfg_valid, input, 1, meaning: request to load cfg_delay.
REQ-013 Port cfg_delay, input, DW=$clog2(MAX_CYCLES+1), meaning: requested latency.
REQ-014 Port cfg_ready, output, 1, meaning: load accepted this cycle if cfg_valid.
REQ-015 Port valid_out, output, 1, meaning: beat present on data_out.
REQ-016 Port data_out, output, LANES*WIDTH, meaning: delayed lane-packed data.
REQ-017 Port cur_delay, output, DW, meaning: latency in force.
REQ-018 Port count, output, DW, meaning: beats in flight.

Function
REQ-019 Datapath SHALL be MAX_CYCLES stages, each a valid bit plus LANES*WIDTH data; stage 0 loads valid_in/data_in, stage i+1 loads stage i, all only when en=1.
REQ-020 Output tap SHALL be stage cur_delay-1: valid_out = tap valid AND en; data_out = tap data.
REQ-021 cur_delay=0 SHALL be combinational bypass: valid_out = valid_in AND en, data_out = data_in; count stays 0.
REQ-022 A beat accepted with en=1 at edge N SHALL appear on valid_out after exactly cur_delay en=1 edges; en=0 cycles add latency without loss or duplication.
REQ-023 Data SHALL be unchanged across lanes; no lane reordering.
REQ-024 cfg_ready SHALL be (count==0) AND NOT valid_in AND NOT flush.
REQ-025 On cfg_valid AND cfg_ready: cur_delay <= min(cfg_delay, MAX_CYCLES) next edge; all stage valid bits cleared the same edge; en does not gate the load.
REQ-026 count SHALL +1 on edge with en, valid_in, cur_delay>0, no flush; -1 on edge with valid_out=1, no flush; unchanged if both; never wraps (max MAX_CYCLES).
REQ-027 flush=1 SHALL clear all valid bits and count on that edge regardless of en; concurrent valid_in beat dropped; concurrent valid_out beat still presented combinationally.
REQ-028 Stage data registers SHALL not be cleared by flush or config load; only valid bits.
REQ-029 Valid bits in stages >= cur_delay SHALL never drive valid_out or count.

Reset
REQ-030 rst_n low SHALL immediately clear all valid bits, count=0, cur_delay=DEFAULT_DELAY, every lane of every stage=INIT_VAL.
REQ-031 During reset valid_out=0 (unless DEFAULT_DELAY=0, where it follows valid_in AND en), cfg_ready per REQ-024.
REQ-032 Reset asserted mid-operation SHALL discard all in-flight beats without emitting any.

Structure
REQ-033 Package var_delay_pkg SHALL hold the delay-width function and the default parameter constants.
REQ-034 One sub-module var_delay_stage (valid+data register with en, flush, async active-low reset, INIT_VAL) SHALL be instantiated MAX_CYCLES times via generate.
REQ-035 Elaboration SHALL fail if DEFAULT_DELAY > MAX_CYCLES or MAX_CYCLES < 1.

Verification (MAX_CYCLES=8, WIDTH=16, LANES=2, DEFAULT_DELAY=3)
REQ-036 Reset, en=1, beats 0x0001_0002,0x0003_0004 on consecutive cycles -> valid_out at edges 3,4 with same data; count peaks 2, returns 0.
REQ-037 Load cfg_delay=0, drive 0xAAAA_5555 -> data_out=0xAAAA_5555, valid_out=1 same cycle; count 0.
REQ-038 Delay 5, one beat, en low 2 cycles mid-flight -> beat emerges after 7 cycles exactly once.
REQ-039 Delay 8, 3 beats in flight, flush + valid_in together -> count=0 next cycle, no valid_out for 10 cycles.
REQ-040 cfg_valid with count=2 -> cfg_ready=0, cur_delay unchanged until drained; cfg_delay=12 -> cur_delay=8.
REQ-041 rst_n low with 4 beats in flight -> valid_out 0, count 0, cur_delay 3, data_out 0x0000_0000.
